// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, segment code table and FSM states for the 7-segment scan decoder
package seg7_pkg;
   localparam logic SEG_ACTIVE_LOW = 1'b1;
   localparam logic [6:0] SEG_CODE [10] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
      7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
   };
   localparam logic [3:0] AN_D0    = 4'b1110;
   localparam logic [3:0] AN_D1    = 4'b1101;
   localparam logic [3:0] AN_D2    = 4'b1011;
   localparam logic [3:0] AN_D3    = 4'b0111;
   localparam logic [3:0] AN_BLANK = 4'b1111;
   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, HOLD} state_e;
endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: maps a segment pattern to its BCD digit, hit=0 when not in the table
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] y,
   output logic       hit,
   output logic [3:0] bcd
);
   logic [6:0] pat;
   always_comb begin
      pat = SEG_ACTIVE_LOW ? y : ~y;
      hit = 1'b0;
      bcd = 4'd0;
      for (int i = 0; i < 10; i++)
         if (pat == SEG_CODE[i]) begin
            hit = 1'b1;
            bcd = 4'(i);
         end
   end
endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: rebuilds four BCD digits from scanned anode/segment lines and flags scan faults
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int STALL_CYCLES  = 400000,
   parameter int CNT_W         = 20
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [6:0]  y,
   input  logic [3:0]  Anode_Activate,
   output logic [15:0] digits,
   output logic [3:0]  digit_valid,
   output logic        frame_valid,
   output logic [15:0] frame_digits,
   output logic        seg_error,
   output logic        anode_error,
   output logic        scan_stall
);
   logic [3:0] an_q, an_p_q, valid_q, valid_d, fresh_q, fresh_d, bcd, sel;
   logic [6:0] y_q, y_p_q;
   logic [15:0] digits_q, digits_d, frame_digits_q, frame_digits_d;
   logic [CNT_W-1:0] set_cnt_q, set_cnt_d, stall_cnt_q, stall_cnt_d;
   logic frame_q, frame_d, seg_err_q, seg_err_d, an_err_q, an_err_d;
   logic an_chg, chg, smp, one, hit;
   state_e state_q, state_d;

   seg7_pattern_decode u_dec (.y(y_q), .hit(hit), .bcd(bcd));

   always_comb begin
      an_chg = an_q != an_p_q;
      chg = an_chg || (y_q != y_p_q);
      sel = ~an_q;
      one = $onehot(sel);
      state_d = state_q;
      set_cnt_d = '0;
      if (chg) state_d = SETTLE;
      else if (state_q == SETTLE) begin
         state_d = (set_cnt_q == CNT_W'(SETTLE_CYCLES - 1)) ? SAMPLE : SETTLE;
         set_cnt_d = set_cnt_q + CNT_W'(1);
      end else if (state_q == SAMPLE) state_d = HOLD;
      // a change landing in the SAMPLE cycle means the value was not settled after all
      smp = (state_q == SAMPLE) && !chg;
      stall_cnt_d = an_chg ? '0 :
                    (stall_cnt_q == CNT_W'(STALL_CYCLES)) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
      frame_d = fresh_q == 4'hF;
      frame_digits_d = frame_d ? digits_q : frame_digits_q;
      fresh_d = frame_d ? 4'h0 : fresh_q;
      digits_d = digits_q;
      valid_d = valid_q;
      seg_err_d = smp && one && !hit;
      an_err_d = smp && !one && (an_q != AN_BLANK);
      for (int k = 0; k < 4; k++)
         if (smp && one && sel[k]) begin
            digits_d[4*k +: 4] = hit ? bcd : digits_q[4*k +: 4];
            valid_d[k] = hit;
            fresh_d[k] = hit;
         end
   end

   always_ff @(posedge clk)
      if (!rstn) begin
         an_q <= '0;
         an_p_q <= '0;
         y_q <= '0;
         y_p_q <= '0;
         state_q <= IDLE;
         set_cnt_q <= '0;
         stall_cnt_q <= '0;
         digits_q <= '0;
         valid_q <= '0;
         fresh_q <= '0;
         frame_q <= 1'b0;
         frame_digits_q <= '0;
         seg_err_q <= 1'b0;
         an_err_q <= 1'b0;
      end else begin
         an_q <= Anode_Activate;
         an_p_q <= an_q;
         y_q <= y;
         y_p_q <= y_q;
         state_q <= state_d;
         set_cnt_q <= set_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         digits_q <= digits_d;
         valid_q <= valid_d;
         fresh_q <= fresh_d;
         frame_q <= frame_d;
         frame_digits_q <= frame_digits_d;
         seg_err_q <= seg_err_d;
         an_err_q <= an_err_d;
      end

   assign digits = digits_q;
   assign digit_valid = valid_q;
   assign frame_valid = frame_q;
   assign frame_digits = frame_digits_q;
   assign seg_error = seg_err_q;
   assign anode_error = an_err_q;
   assign scan_stall = stall_cnt_q == CNT_W'(STALL_CYCLES);
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed self-checking bench for the 7-segment scan decoder
module tb_seg7_scan_decoder;
   import seg7_pkg::*;
   localparam logic [6:0] S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110, S4 = 7'b1001100;
   localparam logic [6:0] S5 = 7'b0100100, S6 = 7'b0100000, S7 = 7'b0001111, S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0000100, SB = 7'b1111111, SX = 7'b0110000;
   logic clk = 1'b0, rstn = 1'b0;
   logic [6:0] y = SB;
   logic [3:0] an = AN_BLANK;
   logic [15:0] digits, frame_digits;
   logic [3:0] digit_valid;
   logic frame_valid, seg_error, anode_error, scan_stall;
   int vecs = 0, errs = 0, n_frame = 0, n_seg = 0, n_an = 0, b_frame = 0, b_seg = 0, b_an = 0;

   seg7_scan_decoder #(.SETTLE_CYCLES(4), .STALL_CYCLES(50), .CNT_W(20)) dut (
      .clk(clk), .rstn(rstn), .y(y), .Anode_Activate(an), .digits(digits),
      .digit_valid(digit_valid), .frame_valid(frame_valid), .frame_digits(frame_digits),
      .seg_error(seg_error), .anode_error(anode_error), .scan_stall(scan_stall)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_valid) n_frame <= n_frame + 1;
      if (seg_error) n_seg <= n_seg + 1;
      if (anode_error) n_an <= n_an + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic show(input logic [3:0] a, input logic [6:0] s, input int n);
      @(negedge clk);
      an = a;
      y = s;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic mark;
      b_frame = n_frame;
      b_seg = n_seg;
      b_an = n_an;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_digits"}, digits, 0);
      chk({tag, "_valid"}, digit_valid, 0);
      chk({tag, "_fdigits"}, frame_digits, 0);
      chk({tag, "_flags"}, {frame_valid, seg_error, anode_error, scan_stall}, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rstn = 1'b1;
      mark();
      // scan 1,2,3,4 on d3..d0, with exact first-sample latency on d3
      @(negedge clk);
      an = AN_D3;
      y = S1;
      repeat (6) @(negedge clk);
      chk("lat_before", {digit_valid, digits}, 20'h0_0000);
      @(negedge clk);
      chk("lat_at", {digit_valid, digits}, 20'h8_1000);
      repeat (2) @(negedge clk);
      show(AN_D2, S2, 10);
      show(AN_D1, S3, 10);
      show(AN_D0, S4, 10);
      show(AN_BLANK, SB, 10);
      chk("scan_digits", digits, 16'h1234);
      chk("scan_valid", digit_valid, 4'hF);
      chk("scan_frames", n_frame - b_frame, 1);
      chk("scan_fdigits", frame_digits, 16'h1234);
      chk("scan_errs", (n_seg - b_seg) + (n_an - b_an), 0);
      // too short to settle
      mark();
      show(AN_D0, S9, 3);
      show(AN_BLANK, SB, 10);
      chk("short_digits", digits, 16'h1234);
      chk("short_frames", n_frame - b_frame, 0);
      // two anodes low
      mark();
      show(4'b1100, S8, 10);
      show(AN_BLANK, SB, 10);
      chk("anerr_count", n_an - b_an, 1);
      chk("anerr_digits", digits, 16'h1234);
      chk("anerr_valid", digit_valid, 4'hF);
      // undecodable segments on d1
      mark();
      show(AN_D1, SX, 10);
      show(AN_BLANK, SB, 10);
      chk("segerr_count", n_seg - b_seg, 1);
      chk("segerr_valid", digit_valid, 4'b1101);
      chk("segerr_digits", digits, 16'h1234);
      chk("segerr_frames", n_frame - b_frame, 0);
      // frozen anode, segment-only change midway must not clear the stall counter
      @(negedge clk);
      an = AN_D3;
      y = S1;
      repeat (30) @(negedge clk);
      y = S5;
      repeat (21) @(negedge clk);
      chk("stall_pre", scan_stall, 0);
      @(negedge clk);
      chk("stall_on", scan_stall, 1);
      repeat (8) @(negedge clk);
      chk("stall_hold", scan_stall, 1);
      @(negedge clk);
      an = AN_D2;
      y = S2;
      @(negedge clk);
      chk("stall_lag", scan_stall, 1);
      @(negedge clk);
      chk("stall_clear", scan_stall, 0);
      repeat (8) @(negedge clk);
      chk("stall_digits", digits, 16'h5234);
      // reset after three of four fresh digits
      show(AN_D1, S3, 10);
      mark();
      @(negedge clk);
      rstn = 1'b0;
      an = AN_BLANK;
      y = SB;
      @(negedge clk);
      chk_zero("midrst");
      rstn = 1'b1;
      show(AN_D3, S9, 10);
      show(AN_D2, S8, 10);
      show(AN_D1, S7, 10);
      show(AN_D0, S6, 10);
      show(AN_BLANK, SB, 10);
      chk("rescan_frames", n_frame - b_frame, 1);
      chk("rescan_fdigits", frame_digits, 16'h9876);
      chk("rescan_digits", digits, 16'h9876);
      chk("rescan_valid", digit_valid, 4'hF);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
